// File: rtl/cache_line_serializer.sv
// Line-to-word serializer: takes one cache line per handshake and streams it out as NWORDS
// word beats, aligned or critical-word-first. Optional dirty-word filtering: CACHE_LINE_SERIALIZER_DIRTY_MASK_EN.
module cache_line_serializer #(
    parameter int LINE_BITS = 512,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_val,
    output logic                                     in_rdy,
    input  logic [ADDR_BITS-1:0]                     in_addr,
    input  logic [LINE_BITS-1:0]                     in_data,
`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
    input  logic [LINE_BITS/WORD_BITS-1:0]           in_mask,
`endif
    input  logic                                     in_wrap,
    output logic                                     out_val,
    input  logic                                     out_rdy,
    output logic [ADDR_BITS-1:0]                     out_addr,
    output logic [WORD_BITS-1:0]                     out_data,
    output logic [$clog2(LINE_BITS/WORD_BITS)-1:0]   out_idx,
    output logic                                     out_last,
    output logic                                     busy
);

    localparam int NWORDS   = LINE_BITS / WORD_BITS;
    localparam int IDX_W    = $clog2(NWORDS);
    localparam int CNT_W    = IDX_W + 1;
    localparam int LINE_OFF = $clog2(LINE_BITS / 8);
    localparam int WORD_OFF = $clog2(WORD_BITS / 8);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_nxt;

    logic [LINE_BITS-1:0] data_p1;
    logic [ADDR_BITS-1:0] base_p1;
    logic [IDX_W-1:0]     start_p1;
    logic [CNT_W-1:0]     cnt_p1;

    logic [IDX_W-1:0]     start_in;
    logic [CNT_W-1:0]     cnt_first;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic                 last;
    logic                 empty;
    logic                 accept;
    logic                 out_hs;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^in_addr[WORD_OFF-1:0];

    assign start_in = in_wrap ? in_addr[LINE_OFF-1:WORD_OFF] : '0;
    assign idx      = start_p1 + cnt_p1[IDX_W-1:0];

`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
    // The mask is stored rotated so that bit k is the k-th word in send order.
    logic [NWORDS-1:0] mask_p1;
    logic [NWORDS-1:0] mask_rot_in;

    function automatic logic [CNT_W-1:0] first_from(input logic [NWORDS-1:0] m,
                                                    input logic [CNT_W-1:0]  from);
        first_from = CNT_W'(NWORDS);
        for (int k = NWORDS - 1; k >= 0; k--) begin
            if (k >= int'(from) && m[k]) first_from = CNT_W'(k);
        end
    endfunction

    always_comb begin
        mask_rot_in = '0;
        for (int k = 0; k < NWORDS; k++) begin
            mask_rot_in[k] = in_mask[IDX_W'(start_in + IDX_W'(k))];
        end
    end

    assign cnt_first = first_from(mask_rot_in, '0);
    assign cnt_nxt   = first_from(mask_p1, cnt_p1 + CNT_W'(1));
    assign last      = (cnt_nxt == CNT_W'(NWORDS));
    assign empty     = (mask_p1 == '0);

    always_ff @(posedge clk) begin
        if (accept) mask_p1 <= mask_rot_in;
    end
`else
    assign cnt_first = '0;
    assign cnt_nxt   = cnt_p1 + CNT_W'(1);
    assign last      = (cnt_p1 == CNT_W'(NWORDS - 1));
    assign empty     = 1'b0;
`endif

    assign accept = in_val & in_rdy;
    assign out_hs = out_val & out_rdy;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Capture stage: line, base and start are held for the whole line.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1  <= in_data;
            base_p1  <= {in_addr[ADDR_BITS-1:LINE_OFF], {LINE_OFF{1'b0}}};
            start_p1 <= start_in;
            cnt_p1   <= cnt_first;
        end else if (out_hs) begin
            cnt_p1   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SEND;
            end
            SEND: begin
                if (empty)                state_nxt = IDLE;
                else if (out_hs && last)  state_nxt = accept ? SEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat stage: everything is decoded from registers, only in_rdy sees out_rdy.
    always_comb begin
        in_rdy   = 1'b1;
        out_val  = 1'b0;
        busy     = 1'b0;
        out_addr = '0;
        out_data = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (state == SEND) begin
            busy   = 1'b1;
            in_rdy = out_rdy & last & ~empty;
            if (!empty) begin
                out_val  = 1'b1;
                out_addr = base_p1 | (ADDR_BITS'(idx) << WORD_OFF);
                out_data = data_p1[int'(idx) * WORD_BITS +: WORD_BITS];
                out_idx  = idx;
                out_last = last;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_serializer.sv
// Directed bench for cache_line_serializer at default parameters (16 x 32-bit words).
module tb_cache_line_serializer;

    localparam int LINE_BITS = 512;
    localparam int WORD_BITS = 32;
    localparam int ADDR_BITS = 32;
    localparam int NWORDS    = 16;
    localparam int IDX_W     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_val;
    logic                 in_rdy;
    logic [ADDR_BITS-1:0] in_addr;
    logic [LINE_BITS-1:0] in_data;
    logic                 in_wrap;
    logic                 out_val;
    logic                 out_rdy;
    logic [ADDR_BITS-1:0] out_addr;
    logic [WORD_BITS-1:0] out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 busy;
`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
    logic [NWORDS-1:0]    in_mask;
`endif

    int checks = 0;
    int errors = 0;

    cache_line_serializer #(
        .LINE_BITS(LINE_BITS),
        .WORD_BITS(WORD_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_val(in_val),
        .in_rdy(in_rdy),
        .in_addr(in_addr),
        .in_data(in_data),
`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
        .in_mask(in_mask),
`endif
        .in_wrap(in_wrap),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .out_addr(out_addr),
        .out_data(out_data),
        .out_idx(out_idx),
        .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_line(input logic [31:0] first_word);
        for (int i = 0; i < NWORDS; i++) in_data[i*WORD_BITS +: WORD_BITS] = first_word + 32'(i);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; in_addr = '0; in_wrap = 1'b0; in_data = '0;
`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
        in_mask = 16'hFFFF;
`endif
        tick; tick;
        reset = 1'b0;
        tick;
        #1;
        checks++;
        if ({out_val, busy, in_rdy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl: val=%b busy=%b in_rdy=%b, want 0 0 1", out_val, busy, in_rdy);
        end
        checks++;
        if ({out_addr, out_data, out_idx, out_last} !== '0) begin
            errors++;
            $display("FAIL reset_fields: addr=%h data=%h idx=%0d last=%b, want all 0",
                     out_addr, out_data, out_idx, out_last);
        end
    endtask

    task automatic test_aligned;
        logic [IDX_W-1:0] ei;
        tick;
        fill_line(32'hA000_0000); in_addr = 32'h0000_1044; in_wrap = 1'b0; out_rdy = 1'b1; in_val = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL aligned_in_rdy: got %b want 1", in_rdy);
        end
        tick;
        in_val = 1'b0;
        for (int b = 0; b < NWORDS; b++) begin
            ei = IDX_W'(b);
            #1;
            checks++;
            if ({out_val, out_idx, out_addr, out_data, out_last} !==
                {1'b1, ei, 32'h1040 + 32'(b*4), 32'hA000_0000 + 32'(b), (b == 15)}) begin
                errors++;
                $display("FAIL aligned_beat%0d: val=%b idx=%0d addr=%h data=%h last=%b want idx=%0d addr=%h data=%h last=%b",
                         b, out_val, out_idx, out_addr, out_data, out_last,
                         ei, 32'h1040 + 32'(b*4), 32'hA000_0000 + 32'(b), (b == 15));
            end
            tick;
        end
        #1;
        checks++;
        if ({out_val, in_rdy, busy} !== 3'b010) begin
            errors++;
            $display("FAIL aligned_idle: val=%b in_rdy=%b busy=%b want 0 1 0", out_val, in_rdy, busy);
        end
    endtask

    task automatic test_wrap;
        logic [IDX_W-1:0] ei;
        tick;
        fill_line(32'hA000_0000); in_addr = 32'h0000_1078; in_wrap = 1'b1; out_rdy = 1'b1; in_val = 1'b1;
        tick;
        in_val = 1'b0; in_wrap = 1'b0;
        for (int b = 0; b < NWORDS; b++) begin
            ei = IDX_W'(14 + b);
            #1;
            checks++;
            if ({out_val, out_idx, out_addr, out_data, out_last} !==
                {1'b1, ei, 32'h1040 + 32'(ei)*4, 32'hA000_0000 + 32'(ei), (b == 15)}) begin
                errors++;
                $display("FAIL wrap_beat%0d: val=%b idx=%0d addr=%h data=%h last=%b want idx=%0d addr=%h last=%b",
                         b, out_val, out_idx, out_addr, out_data, out_last,
                         ei, 32'h1040 + 32'(ei)*4, (b == 15));
            end
            tick;
        end
        #1;
        checks++;
        if (out_val !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: val=%b want 0", out_val);
        end
    endtask

    task automatic test_backpressure;
        int nb = 0;
        tick;
        fill_line(32'hB000_0000); in_addr = 32'h0000_2004; in_wrap = 1'b0; out_rdy = 1'b1; in_val = 1'b1;
        tick;
        in_val = 1'b0;
        for (int c = 0; c < 80 && nb < NWORDS; c++) begin
            out_rdy = (c % 3 == 0);
            #1;
            checks++;
            if ({out_val, out_idx, out_addr, out_data, out_last} !==
                {1'b1, IDX_W'(nb), 32'h2000 + 32'(nb*4), 32'hB000_0000 + 32'(nb), (nb == 15)}) begin
                errors++;
                $display("FAIL bp_cycle%0d: val=%b idx=%0d addr=%h data=%h last=%b want idx=%0d data=%h",
                         c, out_val, out_idx, out_addr, out_data, out_last, nb, 32'hB000_0000 + 32'(nb));
            end
            if (out_rdy) nb++;
            tick;
        end
        checks++;
        if (nb != NWORDS) begin
            errors++;
            $display("FAIL bp_count: beats=%0d want %0d", nb, NWORDS);
        end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (out_val !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: val=%b want 0", out_val);
        end
    endtask

    task automatic test_back_to_back;
        tick;
        fill_line(32'hA000_0000); in_addr = 32'h0000_1000; in_wrap = 1'b0; out_rdy = 1'b1; in_val = 1'b1;
        tick;
        in_val = 1'b0;
        for (int b = 0; b < NWORDS; b++) begin
            if (b == 15) begin
                fill_line(32'hC000_0000); in_addr = 32'h0000_3000; in_val = 1'b1;
            end
            #1;
            checks++;
            if ({busy, out_val, out_addr, out_data, out_last} !==
                {2'b11, 32'h1000 + 32'(b*4), 32'hA000_0000 + 32'(b), (b == 15)}) begin
                errors++;
                $display("FAIL b2b_l1_beat%0d: busy=%b val=%b addr=%h data=%h last=%b want addr=%h",
                         b, busy, out_val, out_addr, out_data, out_last, 32'h1000 + 32'(b*4));
            end
            if (b == 15) begin
                checks++;
                if (in_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_rdy: got %b want 1", in_rdy);
                end
            end
            tick;
        end
        in_val = 1'b0;
        for (int b = 0; b < NWORDS; b++) begin
            #1;
            checks++;
            if ({busy, out_val, out_idx, out_addr, out_data, out_last} !==
                {2'b11, IDX_W'(b), 32'h3000 + 32'(b*4), 32'hC000_0000 + 32'(b), (b == 15)}) begin
                errors++;
                $display("FAIL b2b_l2_beat%0d: busy=%b val=%b idx=%0d addr=%h data=%h last=%b want addr=%h data=%h",
                         b, busy, out_val, out_idx, out_addr, out_data, out_last,
                         32'h3000 + 32'(b*4), 32'hC000_0000 + 32'(b));
            end
            tick;
        end
        #1;
        checks++;
        if ({out_val, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: val=%b busy=%b want 0 0", out_val, busy);
        end
    endtask

    task automatic test_reset_mid_line;
        tick;
        fill_line(32'hA000_0000); in_addr = 32'h0000_1040; in_wrap = 1'b0; out_rdy = 1'b1; in_val = 1'b1;
        tick;
        in_val = 1'b0;
        for (int b = 0; b < 5; b++) tick;
        #1;
        checks++;
        if ({out_val, out_idx} !== {1'b1, 4'd5}) begin
            errors++;
            $display("FAIL rst_mid_pre: val=%b idx=%0d want 1 5", out_val, out_idx);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_val, busy, in_rdy, out_addr, out_data, out_idx, out_last} !== {3'b001, 69'd0}) begin
            errors++;
            $display("FAIL rst_mid_after: val=%b busy=%b in_rdy=%b addr=%h data=%h idx=%0d last=%b want 0 0 1 and fields 0",
                     out_val, busy, in_rdy, out_addr, out_data, out_idx, out_last);
        end
        tick;
        fill_line(32'hD000_0000); in_addr = 32'h0000_5000; in_val = 1'b1;
        tick;
        in_val = 1'b0;
        #1;
        checks++;
        if ({out_val, out_idx, out_addr, out_data, out_last} !== {1'b1, 4'd0, 32'h5000, 32'hD000_0000, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_restart: val=%b idx=%0d addr=%h data=%h last=%b want 1 0 5000 d0000000 0",
                     out_val, out_idx, out_addr, out_data, out_last);
        end
        for (int b = 0; b < NWORDS; b++) tick;
        #1;
        checks++;
        if (out_val !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: val=%b want 0", out_val);
        end
    endtask

`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
    task automatic test_dirty_mask;
        logic [IDX_W-1:0] exp_idx [3];
        exp_idx = '{4'd0, 4'd4, 4'd15};
        tick;
        fill_line(32'hA000_0000); in_addr = 32'h0000_1000; in_wrap = 1'b0; in_mask = 16'h8011;
        out_rdy = 1'b1; in_val = 1'b1;
        tick;
        in_val = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if ({out_val, out_idx, out_addr, out_data, out_last} !==
                {1'b1, exp_idx[j], 32'h1000 + 32'(exp_idx[j])*4, 32'hA000_0000 + 32'(exp_idx[j]), (j == 2)}) begin
                errors++;
                $display("FAIL mask_beat%0d: val=%b idx=%0d addr=%h last=%b want idx=%0d last=%b",
                         j, out_val, out_idx, out_addr, out_last, exp_idx[j], (j == 2));
            end
            tick;
        end
        #1;
        checks++;
        if (out_val !== 1'b0) begin
            errors++;
            $display("FAIL mask_idle: val=%b want 0", out_val);
        end
        tick;
        in_mask = 16'h0000; in_val = 1'b1;
        tick;
        in_val = 1'b0;
        #1;
        checks++;
        if ({out_val, in_rdy, busy} !== 3'b001) begin
            errors++;
            $display("FAIL mask_zero_send: val=%b in_rdy=%b busy=%b want 0 0 1", out_val, in_rdy, busy);
        end
        tick;
        #1;
        checks++;
        if ({out_val, in_rdy, busy} !== 3'b010) begin
            errors++;
            $display("FAIL mask_zero_idle: val=%b in_rdy=%b busy=%b want 0 1 0", out_val, in_rdy, busy);
        end
        in_mask = 16'hFFFF;
    endtask
`endif

    initial begin
        test_reset;
        test_aligned;
        test_wrap;
        test_backpressure;
        test_back_to_back;
`ifdef CACHE_LINE_SERIALIZER_DIRTY_MASK_EN
        test_dirty_mask;
`endif
        test_reset_mid_line;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
